fifo_rr_merge: RTL and testbench

Round-robin merger that drains up to four 32-bit first-word-fall-through source FIFOs into one 32-bit output write port. Typical sources are TDC cores. Typical sink is the shared readout FIFO. Data words pass through unmodified, because each source already carries its identifier in the upper bits. The block has burst-limited fairness, a per-source enable mask, and a transferred-word counter.

---
 rtl/fifo_rr_merge_pkg.sv | 15 +
 rtl/fifo_rr_merge_rr_select.sv | 36 +++
 rtl/fifo_rr_merge.sv | 132 +++++++++++++
 tb/tb_fifo_rr_merge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_merge_pkg.sv
// Shared types and widths for the round-robin FIFO merger.
// No logic; imported by the merger and its selector.
// No flow control of its own.
package fifo_rr_merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int DATA_W = 32;
  localparam int BCNT_W = 8;
  localparam int IDX_W  = 2;

endpackage

// File: rtl/fifo_rr_merge_rr_select.sv
// Rotating priority encoder: first asserted req at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_select
  import fifo_rr_merge_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = IDX_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Distance from ptr in the rotated order; smallest distance wins.
  always_comb begin : sel
    int off;
    int best;
    off   = 0;
    best  = N;
    index = '0;
    for (int j = 0; j < N; j++) begin
      off = j - int'(ptr);
      if (off < 0) begin
        off = off + N;
      end
      if (req[j] && off < best) begin
        best  = off;
        index = IW'(j);
      end
    end
    valid = (best < N);
  end

endmodule

// File: rtl/fifo_rr_merge.sv
// Round-robin merge of up to four FWFT source FIFOs into one registered write port.
// Latency: request to OUT_WRITE is 2 cycles (1 arbitration + 1 output register).
// Backpressure: OUT_FULL stalls pops and holds the output word; the grant is kept.
module fifo_rr_merge
  import fifo_rr_merge_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST,
  input  logic [NUM_SRC-1:0]        SRC_EN,
  input  logic [NUM_SRC-1:0]        SRC_EMPTY,
  input  logic [DATA_W*NUM_SRC-1:0] SRC_DATA,
  output logic [NUM_SRC-1:0]        SRC_READ,
  input  logic                      OUT_FULL,
  output logic                      OUT_WRITE,
  output logic [DATA_W-1:0]         OUT_DATA,
  output logic [31:0]               WORD_CNT
);

  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  SRC_LAST   = IDX_W'(NUM_SRC - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_next;
  logic [IDX_W-1:0]    sel_idx;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [NUM_SRC-1:0]  req;
  logic                sel_vld;
  logic                ready;
  logic                grant_req;
  logic                pop;
  logic [DATA_W-1:0]   grant_dat;

  assign req        = SRC_EN & ~SRC_EMPTY;
  assign ready      = ~OUT_WRITE | ~OUT_FULL;
  assign grant_next = (grant_q == SRC_LAST) ? '0 : grant_q + IDX_W'(1);

  rr_select #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_rr_select (
    .req   (req),
    .ptr   (ptr_q),
    .valid (sel_vld),
    .index (sel_idx)
  );

  always_comb begin
    grant_req = 1'b0;
    grant_dat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        grant_req = req[i];
        grant_dat = SRC_DATA[DATA_W*i +: DATA_W];
      end
    end
  end

  assign pop = (state_q == XFER) & grant_req & ready & (bcnt_q < BURST_LAST);

  always_comb begin
    SRC_READ = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      SRC_READ[i] = pop & (grant_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d = sel_idx;
          bcnt_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
        // Losing the request (empty or disabled) can never coincide with a pop.
        if ((pop && (bcnt_q + BCNT_W'(1) == BURST_LAST)) || !grant_req) begin
          state_d = IDLE;
          ptr_d   = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Single-word output register; a held word is only replaced once the sink accepts it.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      OUT_WRITE <= 1'b0;
      OUT_DATA  <= '0;
      WORD_CNT  <= '0;
    end else begin
      if (OUT_WRITE && !OUT_FULL) begin
        WORD_CNT <= WORD_CNT + 32'd1;
      end
      if (pop) begin
        OUT_DATA  <= grant_dat;
        OUT_WRITE <= 1'b1;
      end else if (!OUT_FULL) begin
        OUT_WRITE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Bench for fifo_rr_merge: modelled source FIFOs, per-source ordering scoreboard,
// table of arbitration scenarios and hand-written multi-cycle sequences.
module tb_fifo_rr_merge;

  localparam int NS = 4;
  localparam int MB = 16;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST = 1'b0;
  logic [3:0]    SRC_EN = 4'h0;
  logic [3:0]    SRC_EMPTY = 4'hF;
  logic [127:0]  SRC_DATA = '0;
  logic [3:0]    SRC_READ;
  logic          OUT_FULL = 1'b0;
  logic          OUT_WRITE;
  logic [31:0]   OUT_DATA;
  logic [31:0]   WORD_CNT;

  fifo_rr_merge #(.NUM_SRC(NS), .MAX_BURST(MB)) dut (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST   (BUS_RST),
    .SRC_EN    (SRC_EN),
    .SRC_EMPTY (SRC_EMPTY),
    .SRC_DATA  (SRC_DATA),
    .SRC_READ  (SRC_READ),
    .OUT_FULL  (OUT_FULL),
    .OUT_WRITE (OUT_WRITE),
    .OUT_DATA  (OUT_DATA),
    .WORD_CNT  (WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  int          head[4];
  int          tail[4];
  int          got[4];
  int          pops[4];
  int          first_src;
  logic [31:0] exp_wc;
  logic        held;
  logic [31:0] held_dat;
  logic        obs_wr;
  logic [31:0] obs_dat;
  logic [3:0]  obs_rd;
  bit          rand_full;
  bit          rand_push;
  int          src_log[$];

  typedef struct {
    logic [3:0] en;
    int c0, c1, c2, c3;
    int exp_first;
    int exp_total;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    chk(act == req, name, act, req);
  endtask

  function automatic logic [31:0] word_of(input int i, input int seq);
    return {i[7:0], seq[23:0]};
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      SRC_EMPTY[i] = (head[i] >= tail[i]);
      SRC_DATA[32*i +: 32] = SRC_EMPTY[i] ? 32'hBAD0_0000 : word_of(i, head[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0; tail[i] = 0; got[i] = 0; pops[i] = 0;
    end
    exp_wc = '0;
    held = 1'b0;
    first_src = 4;
    rand_full = 1'b0;
    rand_push = 1'b0;
    src_log.delete();
  endtask

  task automatic do_reset();
    BUS_RST = 1'b1;
    clear_model();
    OUT_FULL = 1'b0;
    SRC_EN = 4'hF;
    drive_srcs();
    repeat (2) @(posedge BUS_CLK);
    #1 BUS_RST = 1'b0;
  endtask

  // One cycle: observe and check at negedge, then update sources #1 after posedge.
  task automatic step();
    int s;
    int pick;
    @(negedge BUS_CLK);
    obs_wr = OUT_WRITE;
    obs_dat = OUT_DATA;
    obs_rd = SRC_READ;
    chk($onehot0(SRC_READ), "read_onehot", {28'd0, SRC_READ}, 32'd0);
    chk((SRC_READ & (SRC_EMPTY | ~SRC_EN)) == 4'd0, "pop_empty_or_disabled", {28'd0, SRC_READ}, {28'd0, ~SRC_EMPTY & SRC_EN});
    if (SRC_READ != 4'd0) begin
      chk(!(OUT_WRITE && OUT_FULL), "pop_not_ready", {28'd0, SRC_READ}, 32'd0);
    end
    if (held) begin
      chk(OUT_WRITE && OUT_DATA == held_dat, "hold_while_full", OUT_DATA, held_dat);
    end
    chk_eq("word_cnt", WORD_CNT, exp_wc);
    if (OUT_WRITE && !OUT_FULL) begin
      s = int'(OUT_DATA[31:24]);
      chk(s < NS, "out_src_id", OUT_DATA, 32'd0);
      if (s < NS) begin
        chk_eq("out_word", OUT_DATA, word_of(s, got[s]));
        chk(got[s] < tail[s], "out_no_extra", got[s], tail[s]);
        got[s]++;
        src_log.push_back(s);
      end
      exp_wc = exp_wc + 32'd1;
    end
    held = OUT_WRITE && OUT_FULL;
    held_dat = OUT_DATA;
    for (int i = 0; i < NS; i++) begin
      if (SRC_READ[i]) begin
        pops[i]++;
        if (first_src == 4) first_src = i;
      end
    end
    @(posedge BUS_CLK);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (obs_rd[i] && head[i] < tail[i]) head[i]++;
    end
    if (rand_full) OUT_FULL = ($urandom_range(0, 1) == 1);
    if (rand_push && $urandom_range(0, 1) == 1) begin
      pick = int'($urandom_range(0, 1));
      tail[pick]++;
    end
    drive_srcs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, n, sum, p, b;
    bit exp_wr;
    int rem[4];
    int model[$];

    clear_model();
    #2 BUS_RST = 1'b1;
    #1;
    chk_eq("rst_out_write", {31'd0, OUT_WRITE}, 32'd0);
    chk_eq("rst_out_data", OUT_DATA, 32'd0);
    chk_eq("rst_word_cnt", WORD_CNT, 32'd0);
    chk_eq("rst_src_read", {28'd0, SRC_READ}, 32'd0);

    // Arbitration scenarios straight after reset (PTR=0).
    vecs[0] = '{4'b1111, 0, 0, 3, 5, 2, 8};
    vecs[1] = '{4'b1010, 2, 2, 2, 2, 1, 4};
    vecs[2] = '{4'b0000, 1, 1, 1, 1, 4, 0};
    vecs[3] = '{4'b1000, 0, 0, 0, 33, 3, 33};
    vecs[4] = '{4'b0110, 5, 0, 7, 0, 2, 7};
    vecs[5] = '{4'b1111, 1, 0, 0, 1, 0, 2};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      SRC_EN = vecs[v].en;
      tail[0] = vecs[v].c0; tail[1] = vecs[v].c1;
      tail[2] = vecs[v].c2; tail[3] = vecs[v].c3;
      drive_srcs();
      repeat (60) step();
      sum = got[0] + got[1] + got[2] + got[3];
      chk_eq("vec_first_grant", first_src, vecs[v].exp_first);
      chk_eq("vec_total", sum, vecs[v].exp_total);
      chk_eq("vec_word_cnt", WORD_CNT, vecs[v].exp_total);
    end

    // Single source, 40 words: 16/16/8 with one idle cycle between bursts.
    do_reset();
    tail[0] = 40;
    drive_srcs();
    for (int j = 1; j <= 50; j++) begin
      step();
      m = j - 3;
      n = (m >= 0) ? m - m / (MB + 1) : 0;
      exp_wr = (m >= 0) && (m % (MB + 1) != MB) && (n < 40);
      chk_eq("single_wr_timing", {31'd0, obs_wr}, {31'd0, exp_wr});
      if (exp_wr) chk_eq("single_word", obs_dat, word_of(0, n));
    end
    chk_eq("single_word_cnt", WORD_CNT, 32'd40);

    // Four busy sources: order follows the rotating burst rule.
    do_reset();
    for (int i = 0; i < NS; i++) tail[i] = 20;
    drive_srcs();
    for (int k = 0; k < 400 && src_log.size() < 80; k++) step();
    model.delete();
    for (int i = 0; i < NS; i++) rem[i] = 20;
    p = 0;
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      while (rem[p] == 0) p = (p + 1) % NS;
      b = (rem[p] < MB) ? rem[p] : MB;
      repeat (b) model.push_back(p);
      rem[p] -= b;
      p = (p + 1) % NS;
    end
    chk_eq("rr_total", src_log.size(), 80);
    for (int k = 0; k < 80; k++) begin
      if (k < src_log.size()) chk_eq("rr_order", src_log[k], model[k]);
    end

    // Random backpressure with two sources and random arrivals.
    do_reset();
    tail[0] = 20;
    tail[1] = 20;
    drive_srcs();
    rand_full = 1'b1;
    rand_push = 1'b1;
    repeat (300) step();
    rand_push = 1'b0;
    for (int k = 0; k < 2000 && !(got[0] == tail[0] && got[1] == tail[1]); k++) step();
    chk_eq("rand_src0_all", got[0], tail[0]);
    chk_eq("rand_src1_all", got[1], tail[1]);
    rand_full = 1'b0;
    OUT_FULL = 1'b0;
    step();
    chk_eq("rand_word_cnt", WORD_CNT, tail[0] + tail[1]);

    // Disable source 1 after three words of its burst.
    do_reset();
    tail[1] = 10;
    tail[2] = 4;
    drive_srcs();
    for (int k = 0; k < 30 && pops[1] < 3; k++) step();
    SRC_EN[1] = 1'b0;
    drive_srcs();
    first_src = 4;
    repeat (20) step();
    chk_eq("dis_src1_pops", pops[1], 3);
    chk_eq("dis_src1_got", got[1], 3);
    chk_eq("dis_next_grant", first_src, 2);
    chk_eq("dis_src2_got", got[2], 4);

    // Asynchronous reset with a word held under backpressure.
    do_reset();
    tail[0] = 2;
    tail[1] = 10;
    drive_srcs();
    for (int k = 0; k < 40 && pops[1] < 3; k++) step();
    OUT_FULL = 1'b1;
    repeat (2) step();
    chk_eq("pre_rst_held", {31'd0, obs_wr}, 32'd1);
    #2 BUS_RST = 1'b1;
    #1;
    chk_eq("async_rst_out_write", {31'd0, OUT_WRITE}, 32'd0);
    chk_eq("async_rst_out_data", OUT_DATA, 32'd0);
    chk_eq("async_rst_word_cnt", WORD_CNT, 32'd0);
    chk_eq("async_rst_src_read", {28'd0, SRC_READ}, 32'd0);
    @(posedge BUS_CLK);
    #1;
    chk_eq("in_rst_src_read", {28'd0, SRC_READ}, 32'd0);
    clear_model();
    tail[0] = 3;
    tail[1] = 3;
    drive_srcs();
    OUT_FULL = 1'b0;
    BUS_RST = 1'b0;
    repeat (15) step();
    chk_eq("post_rst_first_grant", first_src, 0);
    chk_eq("post_rst_src0", got[0], 3);
    chk_eq("post_rst_src1", got[1], 3);

    // Counter wrap.
    force dut.WORD_CNT = 32'hFFFF_FFFF;
    #1 release dut.WORD_CNT;
    exp_wc = 32'hFFFF_FFFF;
    tail[0] = tail[0] + 1;
    drive_srcs();
    repeat (6) step();
    chk_eq("wrap_word_cnt", WORD_CNT, 32'd0);
    chk_eq("wrap_src0", got[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
